// File: rtl/ring_counter.sv
// ---------------------------------------------------------------------------
// ring_counter
//
// Purpose:
//   One-hot ring counter that rotates its single hot bit one place to the
//   right on every clock edge while out of reset. It also reports the
//   binary index of the hot bit, a one-cycle pulse each time the ring comes
//   back to its starting pattern, and a one-cycle error flag whenever an
//   illegal (non one-hot) state was seen and repaired.
//
// Parameters:
//   WIDTH    - number of ring stages (2..32)
//   INIT_POS - index of the hot bit loaded at reset (0..WIDTH-1)
//   POS_W    - derived width of the pos output
//
// Ports:
//   clk  - single clock, all state changes on its rising edge
//   rstn - synchronous reset, active HIGH despite the name (1 = reset)
//   out  - registered one-hot ring state
//   pos  - registered binary index of the hot bit in out
//   wrap - registered one-cycle pulse when out returns to the reset pattern
//   err  - registered one-cycle flag for the cycle after an illegal state
// ---------------------------------------------------------------------------
module ring_counter #(
  parameter int WIDTH    = 4,
  parameter int INIT_POS = 0,
  localparam int POS_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  output logic [WIDTH-1:0] out,
  output logic [POS_W-1:0] pos,
  output logic             wrap,
  output logic             err
);

  // Population counter must hold values up to WIDTH inclusive.
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [WIDTH-1:0] INIT_VEC  = {{(WIDTH-1){1'b0}}, 1'b1} << INIT_POS;
  localparam logic [POS_W-1:0] INIT_IDX  = POS_W'(INIT_POS);
  localparam logic [POS_W-1:0] LAST_IDX  = POS_W'(WIDTH - 1);

  logic [WIDTH-1:0] out_q, out_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  logic [CNT_W-1:0] pop_cnt;
  logic             state_legal;

  // Count the set bits of the current state; anything other than exactly
  // one set bit is an illegal ring state that must be repaired.
  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop_cnt = pop_cnt + CNT_W'(out_q[i]);
    end
    state_legal = (pop_cnt == CNT_W'(1));
  end

  // Next-state logic. A legal state rotates right by one (pure wiring) and
  // the index steps down modulo WIDTH. An illegal state is replaced by the
  // reset pattern and flagged for exactly one cycle; wrap stays low then
  // because the return to the start pattern was not a real rotation.
  always_comb begin
    out_d  = INIT_VEC;
    pos_d  = INIT_IDX;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (state_legal) begin
      out_d  = {out_q[0], out_q[WIDTH-1:1]};
      pos_d  = (pos_q == '0) ? LAST_IDX : (pos_q - POS_W'(1));
      wrap_d = ({out_q[0], out_q[WIDTH-1:1]} == INIT_VEC);
    end else begin
      err_d  = 1'b1;
    end
  end

  // State and output registers. Reset wins over both rotation and
  // self-correction, and is only looked at on the clock edge.
  always_ff @(posedge clk) begin
    if (rstn) begin
      out_q  <= INIT_VEC;
      pos_q  <= INIT_IDX;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      pos_q  <= pos_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign out  = out_q;
  assign pos  = pos_q;
  assign wrap = wrap_q;
  assign err  = err_q;

endmodule

// File: tb/tb_ring_counter.sv
// ---------------------------------------------------------------------------
// tb_ring_counter
//
// Purpose:
//   Self-checking bench for ring_counter. Two instances run side by side:
//   a WIDTH=4/INIT_POS=0 ring and a WIDTH=8/INIT_POS=3 ring. Each directed
//   step drives the resets, pushes the expected post-edge outputs into a
//   per-instance queue, and pops/compares them once the edge has happened.
// ---------------------------------------------------------------------------
module tb_ring_counter;

  typedef struct {
    logic [7:0] out;
    logic [2:0] pos;
    logic       wrap;
    logic       err;
  } exp_t;

  logic       clk;
  logic       rst4, rst8;
  logic [3:0] out4;
  logic [1:0] pos4;
  logic       wrap4, err4;
  logic [7:0] out8;
  logic [2:0] pos8;
  logic       wrap8, err8;

  exp_t q4[$];
  exp_t q8[$];
  exp_t m4, m8;

  int n_cmp  = 0;
  int n_fail = 0;

  ring_counter #(.WIDTH(4), .INIT_POS(0)) d4 (
    .clk (clk),
    .rstn(rst4),
    .out (out4),
    .pos (pos4),
    .wrap(wrap4),
    .err (err4)
  );

  ring_counter #(.WIDTH(8), .INIT_POS(3)) d8 (
    .clk (clk),
    .rstn(rst8),
    .out (out8),
    .pos (pos8),
    .wrap(wrap8),
    .err (err8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference behaviour of one ring of width w with start index ip.
  function automatic exp_t model_next(input int w, input int ip, input logic rst,
                                      input logic [7:0] cur_out, input logic [2:0] cur_pos);
    exp_t       e;
    logic [7:0] init_v;
    logic [7:0] rot;
    init_v = 8'(1) << ip;
    e.wrap = 1'b0;
    e.err  = 1'b0;
    if (rst) begin
      e.out = init_v;
      e.pos = 3'(ip);
    end else if ($countones(cur_out) != 1) begin
      e.out = init_v;
      e.pos = 3'(ip);
      e.err = 1'b1;
    end else begin
      rot = '0;
      for (int i = 0; i < w; i++) rot[i] = cur_out[(i + 1) % w];
      e.out  = rot;
      e.pos  = (cur_pos == 0) ? 3'(w - 1) : cur_pos - 3'd1;
      e.wrap = (rot == init_v);
    end
    return e;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (q4.size() == 0 || q8.size() == 0) begin
      cmp("queue_empty", 32'd1, 32'd0);
      return;
    end
    e = q4.pop_front();
    cmp("w4_out",  32'(out4),  32'(e.out));
    cmp("w4_pos",  32'(pos4),  32'(e.pos));
    cmp("w4_wrap", 32'(wrap4), 32'(e.wrap));
    cmp("w4_err",  32'(err4),  32'(e.err));
    cmp("w4_onehot_pos", 32'(out4), 32'(4'(1) << pos4));
    e = q8.pop_front();
    cmp("w8_out",  32'(out8),  32'(e.out));
    cmp("w8_pos",  32'(pos8),  32'(e.pos));
    cmp("w8_wrap", 32'(wrap8), 32'(e.wrap));
    cmp("w8_err",  32'(err8),  32'(e.err));
    cmp("w8_onehot_pos", 32'(out8), 32'(8'(1) << pos8));
    cmp("no_x", 32'($isunknown({out4, pos4, wrap4, err4, out8, pos8, wrap8, err8})), 32'd0);
  endtask

  // Drive one edge worth of stimulus, record what must come out, then check.
  task automatic applyStimulus(input logic r4, input logic r8);
    exp_t e;
    rst4 = r4;
    rst8 = r8;
    e = model_next(4, 0, r4, m4.out, m4.pos);
    q4.push_back(e);
    m4 = e;
    e = model_next(8, 3, r8, m8.out, m8.pos);
    q8.push_back(e);
    m8 = e;
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    rst4 = 1'b1;
    rst8 = 1'b1;
    m4.out = '0; m4.pos = '0; m4.wrap = 1'b0; m4.err = 1'b0;
    m8.out = '0; m8.pos = '0; m8.wrap = 1'b0; m8.err = 1'b0;

    $display("[TB] reset both rings for two edges");
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);

    $display("[TB] free run 15 cycles");
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b0);

    $display("[TB] mid-sequence reset of the 4-stage ring at 0100");
    for (int i = 0; i < 4 && m4.out[3:0] != 4'b0100; i++) applyStimulus(1'b0, 1'b0);
    cmp("reach_0100", 32'(out4), 32'h4);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);

    $display("[TB] corrupt state to 0000");
    @(negedge clk);
    force d4.out_q = 4'b0000;
    #1;
    release d4.out_q;
    m4.out = 8'h00;
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);

    $display("[TB] corrupt state to 0110");
    @(negedge clk);
    force d4.out_q = 4'b0110;
    #1;
    release d4.out_q;
    m4.out = 8'h06;
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);

    $display("[TB] hold reset on the 8-stage ring for three edges");
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);

    $display("[TB] final free run");
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ring_counter.md
RING_COUNTER -- requirements
Module: ring_counter

Interface
REQ-001 Parameter WIDTH, default 4: number of ring stages; legal range 2..32.
REQ-002 Parameter INIT_POS, default 0: index of the single hot bit loaded at reset; legal range 0..WIDTH-1.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port rstn, input, 1 bit: synchronous, active-high reset; sampled on rising clk; rstn=1 resets, rstn=0 runs.
REQ-005 Port out, output, WIDTH bits: one-hot ring state, registered.
REQ-006 Port pos, output, max(1,clog2(WIDTH)) bits: binary index of the hot bit in out, registered.
REQ-007 Port wrap, output, 1 bit: one-cycle registered pulse marking ring completion.
REQ-008 Port err, output, 1 bit: registered illegal-state flag.
REQ-009 No other ports; block has no handshake and no enable; it advances every non-reset cycle.

Function
REQ-010 Legal out values: exactly one bit set (one-hot).
REQ-011 Each rising clk with rstn=0 and legal state: rotate right by one, i.e. out[i] <= out[i+1] for i < WIDTH-1, out[WIDTH-1] <= out[0].
REQ-012 WIDTH=4, INIT_POS=0 sequence: 0001 -> 1000 -> 0100 -> 0010 -> 0001, period WIDTH cycles.
REQ-013 pos tracks out with zero relative latency: pos == index of the set bit in the same cycle; decrements by 1 per step, WIDTH-1 follows 0.
REQ-014 wrap = 1 for exactly the one cycle in which out returns to the INIT_POS pattern after a rotation; 0 otherwise, including the first cycle after reset.
REQ-015 Illegal state (zero or more than one bit set in out), detected by a population check each cycle: the next edge loads the INIT_POS pattern (self-correction), and err = 1 for that one following cycle.
REQ-016 err = 0 in all other cycles; wrap = 0 in the correction cycle.
REQ-017 Latency: out, pos, wrap, err change only on rising clk; no combinational path from rstn to outputs.
REQ-018 Rotation is pure bit permutation; no arithmetic on out; pos arithmetic is modulo WIDTH.

Reset
REQ-019 rstn=1 at a rising edge: out = 1 << INIT_POS, pos = INIT_POS, wrap = 0, err = 0 after that edge.
REQ-020 Reset has priority over rotation and self-correction; asserting rstn mid-sequence discards the current position.
REQ-021 Rotation resumes on the first rising edge with rstn=0; reset held for N cycles keeps outputs at reset values throughout.
REQ-022 Before the first reset edge, outputs are undefined; the bench shall apply reset for at least one edge.

Verification
REQ-023 Reset 2 cycles, release, run 15 cycles (WIDTH=4) -> out 0001 after reset, then 1000, 0100, 0010, 0001 repeating; pos 0,3,2,1,0.
REQ-024 Same run -> wrap high only in cycles where out returns to 0001 (cycles 4, 8, 12 after release); err always 0.
REQ-025 Assert rstn for one edge while out = 0100 -> next out 0001, pos 0, wrap 0; rotation continues to 1000 on the following edge.
REQ-026 Force out to 0000 and separately to 0110 (bench force/release on state) -> next edge out = 0001, err = 1 for one cycle, then normal rotation.
REQ-027 WIDTH=8, INIT_POS=3 -> reset out 00001000; one-hot rotation right, period 8; wrap every 8th cycle; pos 3,2,1,0,7,...
REQ-028 Every cycle check: out one-hot (after reset), out == 1 << pos, no X on any output.
